ncl_dr_tx: RTL and testbench

Clocked single-rail to dual-rail NCL transmitter. It accepts words from a synchronous valid/ready source and emits them as 4-phase NCL wavefronts (DATA, then NULL) on true/false rail pairs. It paces itself on the asynchronous acknowledge `ki` returned by the downstream NCL pipeline built from our threshold-gate cells. It is the sending end of the dual-rail links whose NULL/DATA completion the TH-gate completion trees detect.

---
 rtl/ncl_dr_tx.sv | 114 +++++++++++
 tb/tb_ncl_dr_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_dr_tx.sv
// Clocked single-rail to dual-rail NCL transmitter: emits each accepted word as a DATA wavefront
// followed by NULL, paced by the synchronized receiver acknowledge ki.
module ncl_dr_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ki,
  output logic [WIDTH-1:0] out_t,
  output logic [WIDTH-1:0] out_f,
  output logic             busy,
  output logic             err,
  output logic [15:0]      word_cnt
);

  localparam int unsigned TmoW = $clog2(TIMEOUT);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSendData,
    StSendNull
  } state_e;

  state_e            state_q, state_d;
  logic              ki_meta_q, ki_s_q;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  out_t_q, out_t_d;
  logic [WIDTH-1:0]  out_f_q, out_f_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;

  // Only registered state feeds in_ready, so there is no path from in_valid.
  assign in_ready = (state_q == StIdle) && ki_s_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = tmo_q;
    err_d      = err_q;

    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          state_d = StSendData;
        end
      end
      StSendData: begin
        if (!ki_s_q) state_d = StSendNull;
      end
      StSendNull: begin
        if (ki_s_q) begin
          state_d    = StIdle;
          word_cnt_d = word_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Handshake watchdog: restarts on every state entry, saturates, and only flags.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q != StIdle) begin
      if (tmo_q != TmoMax) tmo_d = tmo_q + TmoW'(1);
      if (tmo_d == TmoMax) err_d = 1'b1;
    end

    // Rails derive from the next state so DATA lands on the same edge as the accept.
    out_t_d = (state_d == StSendData) ? data_d  : '0;
    out_f_d = (state_d == StSendData) ? ~data_d : '0;
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ki_meta_q  <= 1'b0;
      ki_s_q     <= 1'b0;
      state_q    <= StIdle;
      data_q     <= '0;
      out_t_q    <= '0;
      out_f_q    <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
      tmo_q      <= '0;
    end else begin
      ki_meta_q  <= ki;
      ki_s_q     <= ki_meta_q;
      state_q    <= state_d;
      data_q     <= data_d;
      out_t_q    <= out_t_d;
      out_f_q    <= out_f_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign out_t    = out_t_q;
  assign out_f    = out_f_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_ncl_dr_tx.sv
// Bench for ncl_dr_tx: directed timing checks plus randomized traffic against a small receiver
// model and a per-cycle rail monitor.
module tb_ncl_dr_tx;

  localparam int unsigned W = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          ki;
  logic [W-1:0]  out_t;
  logic [W-1:0]  out_f;
  logic          busy;
  logic          err;
  logic [15:0]   word_cnt;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;

  logic          rx_auto;
  int unsigned   rx_dly;
  logic          ki_auto;
  logic          ki_man;
  logic [15:0]   exp_cnt;
  logic          mon_en;

  assign ki = rx_auto ? ki_auto : ki_man;

  ncl_dr_tx #(
    .WIDTH   (W),
    .TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .ki       (ki),
    .out_t    (out_t),
    .out_f    (out_f),
    .busy     (busy),
    .err      (err),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receiver model: acknowledges DATA by dropping ki and NULL by raising it, after 0..rx_dly cycles.
  initial begin
    ki_auto = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rx_auto) begin
        if (ki_auto && ((out_t | out_f) != '0)) begin
          repeat ($urandom_range(0, rx_dly)) @(posedge clk);
          #2 ki_auto = 1'b0;
        end else if (!ki_auto && ((out_t | out_f) == '0)) begin
          repeat ($urandom_range(0, rx_dly)) @(posedge clk);
          #2 ki_auto = 1'b1;
        end
      end
    end
  end

  // Rail monitor: exclusivity, complete wavefronts, no DATA->DATA, accepted word on the next edge.
  logic [W-1:0] prev_t, prev_f, exp_w;
  logic         prev_data, acc_pend;
  initial begin
    prev_data = 1'b0;
    acc_pend  = 1'b0;
  end
  always @(negedge clk) begin
    if (mon_en) begin
      check("rail_excl", 32'(out_t & out_f), 32'd0);
      check("rail_complete", 32'(((out_t | out_f) == '0) || ((out_t | out_f) == '1)), 32'd1);
      if (prev_data && ((out_t | out_f) != '0))
        check("no_data_to_data", {out_t, out_f}, {prev_t, prev_f});
      if (acc_pend) begin
        check("accept_rails", {out_t, out_f}, {exp_w, ~exp_w});
        check("accept_busy", 32'(busy), 32'd1);
      end
      acc_pend  <= rst_n && in_valid && in_ready;
      exp_w     <= in_data;
      prev_t    <= out_t;
      prev_f    <= out_f;
      prev_data <= ((out_t | out_f) != '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] words [3];
    int n;
    words   = '{8'h00, 8'hFF, 8'h3C};
    rst_n   = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    ki_man  = 1'b1;
    rx_auto = 1'b0;
    rx_dly  = 0;
    exp_cnt = '0;
    mon_en  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_t", 32'(out_t), 32'd0);
    check("rst_out_f", 32'(out_f), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    tick();
    check("ready_sync_1", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("ready_sync_3", 32'(in_ready), 32'd1);

    // Reset during SEND_DATA with ki low
    send_word(8'hC3);
    rst_n  = 1'b0;
    ki_man = 1'b0;
    @(negedge clk);
    tick();
    check("midrst_rails", {out_t, out_f}, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cnt", 32'(word_cnt), 32'(exp_cnt));
    check("midrst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_ready_low", 32'(in_ready), 32'd0);
    end
    ki_man = 1'b1;
    n = 0;
    while (!in_ready && n < 6) begin
      tick();
      n++;
    end
    check("midrst_ready_lat", 32'(n <= 3 && in_ready), 32'd1);
    check("midrst_cnt_after", 32'(word_cnt), 32'(exp_cnt));

    // 0xA5 with hand-driven ki to measure the edge latencies
    send_word(8'hA5);
    ki_man = 1'b0;
    @(negedge clk);
    check("a5_rails_0", {out_t, out_f}, {8'hA5, 8'h5A});
    tick();
    check("a5_rails_1", {out_t, out_f}, {8'hA5, 8'h5A});
    tick();
    check("a5_rails_2", {out_t, out_f}, {8'hA5, 8'h5A});
    tick();
    check("a5_rails_null", {out_t, out_f}, 32'd0);
    check("a5_busy_null", 32'(busy), 32'd1);
    ki_man = 1'b1;
    tick();
    tick();
    check("a5_busy_late", 32'(busy), 32'd1);
    check("a5_cnt_late", 32'(word_cnt), 32'(exp_cnt));
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check("a5_busy_done", 32'(busy), 32'd0);
    check("a5_cnt_done", 32'(word_cnt), 32'(exp_cnt));
    check("a5_ready_done", 32'(in_ready), 32'd1);

    // Back-to-back with in_valid held high and an ideal receiver
    rx_auto = 1'b1;
    rx_dly  = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = words[0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("b2b_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      if (i < 2) in_data = words[i+1];
      else in_valid = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
    end
    wait_idle("b2b_idle");
    check("b2b_cnt", 32'(word_cnt), 32'(exp_cnt));

    // Randomized traffic with a slower, jittery receiver
    rx_dly = 3;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_word(W'($urandom));
      exp_cnt = exp_cnt + 16'd1;
    end
    wait_idle("rand_idle");
    check("rand_cnt", 32'(word_cnt), 32'(exp_cnt));
    check("rand_err", 32'(err), 32'd0);

    // Stalled receiver: err on the 16th cycle in SEND_DATA, then normal completion
    rx_auto = 1'b0;
    ki_man  = 1'b1;
    send_word(8'h69);
    @(negedge clk);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 14) check("tmo_err_early", 32'(err), 32'd0);
      if (k == 15) begin
        check("tmo_err_set", 32'(err), 32'd1);
        check("tmo_rails_hold", {out_t, out_f}, {8'h69, 8'h96});
      end
    end
    ki_man = 1'b0;
    n = 0;
    while (((out_t | out_f) != '0) && n < 10) begin
      tick();
      n++;
    end
    check("tmo_null", {out_t, out_f}, 32'd0);
    ki_man = 1'b1;
    wait_idle("tmo_idle");
    exp_cnt = exp_cnt + 16'd1;
    check("tmo_cnt", 32'(word_cnt), 32'(exp_cnt));
    check("tmo_err_sticky", 32'(err), 32'd1);

    // word_cnt wrap
    rx_auto = 1'b1;
    rx_dly  = 0;
    @(posedge clk);
    #1 force dut.word_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1 release dut.word_cnt_q;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    check("wrap_preset", 32'(word_cnt), 32'(exp_cnt));
    send_word(8'h5C);
    exp_cnt = exp_cnt + 16'd1;
    wait_idle("wrap_idle");
    check("wrap_cnt", 32'(word_cnt), 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
